// File: rtl/mem_sweep_ctrl.sv
// Purpose : arbitrates one simple dual-port RAM between a user port and a FILL/CHECK sweep engine.
// Latency : user reads return RD_LAT cycles after grant; FILL takes DEPTH_MEM cycles, CHECK DEPTH_MEM+RD_LAT.
// Backpr. : none queued; user requests are granted only in IDLE and dropped otherwise.
//
// Ports:
//   clk/reset             clock, synchronous active-high reset
//   start/cmd/seed/abort  sweep control (cmd 0=FILL 1=CHECK 2=FILL+CHECK 3=ignored)
//   usr_*                 user request/grant/read-return port
//   mem_*                 RAM interface (registered read of RD_LAT cycles)
//   busy/done/aborted     sweep status
//   err_cnt/first_err_addr CHECK result (saturating count, first mismatching address)
module mem_sweep_ctrl #(
    parameter int WID_MEM   = 8,
    parameter int DEPTH_MEM = 2048,
    parameter int RD_LAT    = 1,
    parameter int ERR_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         cmd,
    input  logic [15:0]        seed,
    input  logic               abort,
    input  logic               usr_re,
    input  logic               usr_we,
    input  logic [31:0]        usr_addr,
    input  logic [WID_MEM-1:0] usr_din,
    output logic               usr_gnt,
    output logic               usr_rvalid,
    output logic [WID_MEM-1:0] usr_dout,
    output logic [31:0]        mem_raddr,
    output logic [31:0]        mem_waddr,
    output logic [WID_MEM-1:0] mem_din,
    output logic               mem_we,
    input  logic [WID_MEM-1:0] mem_dout,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [31:0]        first_err_addr
);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_CHECK, S_DRAIN, S_DONE} state_t;

    localparam logic [31:0]      LAST_ADDR  = 32'(DEPTH_MEM - 1);
    localparam logic [31:0]      DRAIN_LAST = 32'(RD_LAT - 1);
    localparam logic [ERR_W-1:0] ERR_MAX    = '1;

    state_t              state, state_nxt;
    logic [31:0]         addr;          // sweep address; reused as the DRAIN cycle counter
    logic [15:0]         seed_q;
    logic                then_check;    // cmd 2: FILL continues into CHECK
    logic [RD_LAT-1:0]   urd_vld;
    logic [RD_LAT-1:0]   urd_oob;
    logic [RD_LAT-1:0]   chk_vld;
    logic [31:0]         chk_addr [RD_LAT];
    logic                sweep_rd;
    logic                start_ok;
    logic                in_range;
    logic                abort_sweep;
    logic                mismatch;

    // {16'(a) ^ seed} replicated over the word, truncated to WID_MEM bits
    function automatic logic [WID_MEM-1:0] pattern(input logic [15:0] a, input logic [15:0] s);
        logic [15:0]        v;
        logic [WID_MEM-1:0] p;
        v = a ^ s;
        p = '0;
        for (int i = 0; i < WID_MEM; i++) p[i] = v[i % 16];
        return p;
    endfunction

    assign start_ok    = (state == S_IDLE) && start && (cmd != 2'd3);
    assign in_range    = usr_addr < 32'(DEPTH_MEM);
    assign abort_sweep = abort && (state == S_FILL || state == S_CHECK || state == S_DRAIN);
    assign mismatch    = chk_vld[RD_LAT-1] &&
                         (mem_dout != pattern(chk_addr[RD_LAT-1][15:0], seed_q));

    always_comb begin
        state_nxt = state;
        usr_gnt   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_raddr = '0;
        mem_din   = '0;
        busy      = 1'b0;
        done      = 1'b0;
        sweep_rd  = 1'b0;
        unique case (state)
            S_IDLE: begin
                usr_gnt = usr_re | usr_we;
                // out-of-range requests are granted but never touch the RAM
                if (usr_we && in_range) begin
                    mem_we    = 1'b1;
                    mem_waddr = usr_addr;
                    mem_din   = usr_din;
                end
                if (usr_re && in_range) mem_raddr = usr_addr;
                if (start_ok) state_nxt = (cmd == 2'd1) ? S_CHECK : S_FILL;
            end
            S_FILL: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    mem_we    = 1'b1;
                    mem_waddr = addr;
                    mem_din   = pattern(addr[15:0], seed_q);
                    if (addr == LAST_ADDR) state_nxt = then_check ? S_CHECK : S_DONE;
                end
            end
            S_CHECK: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    mem_raddr = addr;
                    sweep_rd  = 1'b1;
                    if (addr == LAST_ADDR) state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (abort) state_nxt = S_IDLE;
                else if (addr == DRAIN_LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // hold every combinational output low while reset is asserted
        if (reset) begin
            usr_gnt   = 1'b0;
            mem_we    = 1'b0;
            mem_waddr = '0;
            mem_raddr = '0;
            mem_din   = '0;
            busy      = 1'b0;
            done      = 1'b0;
        end
    end

    assign usr_rvalid = urd_vld[RD_LAT-1] && !reset;
    assign usr_dout   = (usr_rvalid && !urd_oob[RD_LAT-1]) ? mem_dout : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            addr           <= '0;
            seed_q         <= '0;
            then_check     <= 1'b0;
            aborted        <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            urd_vld        <= '0;
            urd_oob        <= '0;
            chk_vld        <= '0;
            for (int i = 0; i < RD_LAT; i++) chk_addr[i] <= '0;
        end else begin
            state <= state_nxt;

            // counter restarts on every state change, so it never runs past the last word
            if (state_nxt != state) addr <= '0;
            else if (state == S_FILL || state == S_CHECK || state == S_DRAIN) addr <= addr + 32'd1;

            // user read return pipe, independent of the sweep so in-flight reads finish on time
            urd_vld[0] <= (state == S_IDLE) && usr_re;
            urd_oob[0] <= !in_range;
            for (int i = 1; i < RD_LAT; i++) begin
                urd_vld[i] <= urd_vld[i-1];
                urd_oob[i] <= urd_oob[i-1];
            end

            // sweep compare pipe: address travels alongside the outstanding read
            chk_vld[0]  <= sweep_rd;
            chk_addr[0] <= addr;
            for (int i = 1; i < RD_LAT; i++) begin
                chk_vld[i]  <= chk_vld[i-1];
                chk_addr[i] <= chk_addr[i-1];
            end

            if (abort_sweep) begin
                aborted <= 1'b1;
                chk_vld <= '0;
            end else if (mismatch) begin
                if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
                if (err_cnt == '0) first_err_addr <= chk_addr[RD_LAT-1];
            end

            if (start_ok) begin
                seed_q         <= seed;
                then_check     <= (cmd == 2'd2);
                aborted        <= 1'b0;
                err_cnt        <= '0;
                first_err_addr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
module tb_mem_sweep_ctrl;

    localparam int WID   = 8;
    localparam int DEPTH = 2048;
    localparam int RDL   = 2;
    localparam int EW    = 4;

    logic            clk, reset, start, abort, usr_re, usr_we;
    logic [1:0]      cmd;
    logic [15:0]     seed;
    logic [31:0]     usr_addr;
    logic [WID-1:0]  usr_din;
    logic            usr_gnt, usr_rvalid;
    logic [WID-1:0]  usr_dout, mem_din, mem_dout;
    logic [31:0]     mem_raddr, mem_waddr, first_err_addr;
    logic            mem_we, busy, done, aborted;
    logic [EW-1:0]   err_cnt;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int            when;
        logic [EW-1:0] err;
        logic [31:0]   faddr;
    } done_exp_t;

    logic [WID-1:0] rd_q [$];
    done_exp_t      done_q [$];
    done_exp_t      de;

    mem_sweep_ctrl #(.WID_MEM(WID), .DEPTH_MEM(DEPTH), .RD_LAT(RDL), .ERR_W(EW)) dut (
        .clk(clk), .reset(reset), .start(start), .cmd(cmd), .seed(seed), .abort(abort),
        .usr_re(usr_re), .usr_we(usr_we), .usr_addr(usr_addr), .usr_din(usr_din),
        .usr_gnt(usr_gnt), .usr_rvalid(usr_rvalid), .usr_dout(usr_dout),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_dout(mem_dout), .busy(busy), .done(done), .aborted(aborted),
        .err_cnt(err_cnt), .first_err_addr(first_err_addr)
    );

    // RAM with RDL-cycle registered read
    logic [WID-1:0] ram [DEPTH];
    logic [WID-1:0] rd_pipe [RDL];

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;
        for (int i = 0; i < RDL; i++) rd_pipe[i] = '0;
    end

    always @(posedge clk) begin
        if (mem_we) ram[mem_waddr[10:0]] <= mem_din;
        rd_pipe[0] <= ram[mem_raddr[10:0]];
        for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_dout = rd_pipe[RDL-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents read data or a done pulse
    always @(negedge clk) begin
        if (!reset) begin
            if (usr_rvalid) begin
                if (rd_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rd_unexpected: got dout %0h with no read pending", usr_dout);
                end else begin
                    chk("usr_dout", usr_dout, rd_q.pop_front());
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL done_unexpected: done at cycle %0d, none expected", cyc);
                end else begin
                    de = done_q.pop_front();
                    chk("done_cycle", cyc, de.when);
                    chk("done_err_cnt", 32'(err_cnt), 32'(de.err));
                    chk("done_first_err_addr", first_err_addr, de.faddr);
                end
            end
        end
    end

    task automatic do_start(input logic [1:0] c, input logic [15:0] s, input bit exp_done,
                            input int len, input logic [EW-1:0] e_err, input logic [31:0] e_addr);
        done_exp_t x;
        start = 1'b1; cmd = c; seed = s;
        if (exp_done) begin
            x.when = cyc + len; x.err = e_err; x.faddr = e_addr;
            done_q.push_back(x);
        end
        tick;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, output int wes);
        bit ok;
        ok  = 1'b0;
        wes = 0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (busy && mem_we) wes++;
            if (!busy && !done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL %s_timeout: busy still %0b after 6000 cycles, required 0", name, busy);
        end
        tick;
    endtask

    task automatic usr_read(input logic [31:0] a, input logic [WID-1:0] exp);
        usr_re = 1'b1; usr_addr = a;
        rd_q.push_back(exp);
        @(negedge clk);
        chk("rd_gnt", usr_gnt, 1);
        tick;
        usr_re = 1'b0;
    endtask

    task automatic usr_write(input logic [31:0] a, input logic [WID-1:0] d);
        usr_we = 1'b1; usr_addr = a; usr_din = d;
        @(negedge clk);
        chk("wr_gnt", usr_gnt, 1);
        tick;
        usr_we = 1'b0;
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  n;
        int  gnt_hits;
        bit  ok;
        reset = 1'b1; start = 1'b0; abort = 1'b0; usr_re = 1'b0; usr_we = 1'b0;
        cmd = 2'd0; seed = '0; usr_addr = '0; usr_din = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_flags", {26'd0, busy, done, aborted, usr_gnt, usr_rvalid, mem_we}, 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_first_err_addr", first_err_addr, 0);
        chk("rst_mem_addr", mem_raddr | mem_waddr, 0);
        chk("rst_data", {16'd0, usr_dout, mem_din}, 0);
        tick;
        reset = 1'b0;
        tick;

        // FILL, seed 00A5: pattern(a) = a[7:0] ^ A5
        do_start(2'd0, 16'h00A5, 1'b1, 2049, 0, 0);
        wait_idle("fill", n);
        chk("fill_writes", n, 2048);
        usr_read(3, 8'hA6);
        usr_read(0, 8'hA5);
        usr_read(2047, 8'h5A);

        // CHECK of clean contents
        do_start(2'd1, 16'h00A5, 1'b1, 2048 + RDL + 1, 0, 0);
        wait_idle("check_clean", n);

        // corrupt RAM[100] (was C1), plus an out-of-range write/read
        usr_write(100, 8'h00);
        usr_re = 1'b1; usr_we = 1'b1; usr_addr = 5000; usr_din = 8'hFF;
        rd_q.push_back(8'h00);
        @(negedge clk);
        chk("oob_gnt", usr_gnt, 1);
        chk("oob_mem_we", mem_we, 0);
        tick;
        usr_re = 1'b0; usr_we = 1'b0;
        usr_read(904, 8'h2D);
        do_start(2'd1, 16'h00A5, 1'b1, 2048 + RDL + 1, 1, 100);
        wait_idle("check_err", n);
        usr_read(100, 8'h00);

        // FILL+CHECK, seed 1234, usr_re held high at address 5
        usr_re = 1'b1; usr_addr = 5;
        rd_q.push_back(8'hA0);
        do_start(2'd2, 16'h1234, 1'b1, 4096 + RDL + 1, 0, 0);
        gnt_hits = 0;
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (busy || done) begin
                if (usr_gnt) gnt_hits++;
            end else begin
                ok = 1'b1;
                break;
            end
        end
        chk("sweep_gnt_hits", gnt_hits, 0);
        if (ok) begin
            chk("post_done_gnt", usr_gnt, 1);
            rd_q.push_back(8'h31);
        end else begin
            tests++; fails++;
            $display("FAIL fill_check_timeout: busy still %0b after 6000 cycles, required 0", busy);
        end
        tick;
        usr_re = 1'b0;
        repeat (4) tick;

        // abort while FILL is at address 500
        do_start(2'd0, 16'h00A5, 1'b0, 0, 0, 0);
        repeat (500) tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_aborted", aborted, 1);
        tick;
        usr_read(600, 8'h6C);
        usr_read(499, 8'h56);
        // reserved cmd is ignored and leaves the sticky flag alone
        do_start(2'd3, 16'h0000, 1'b0, 0, 0, 0);
        @(negedge clk);
        chk("cmd3_busy", busy, 0);
        chk("cmd3_aborted", aborted, 1);
        tick;

        // CHECK with seed 1234: addresses 0..499 hold the A5 pattern -> 500 mismatches, saturates
        do_start(2'd1, 16'h1234, 1'b1, 2048 + RDL + 1, 4'hF, 0);
        @(negedge clk);
        chk("start_clears_aborted", aborted, 0);
        tick;
        repeat (100) tick;
        do_start(2'd0, 16'h0000, 1'b0, 0, 0, 0);
        wait_idle("check_sat", n);

        repeat (5) tick;
        chk("rd_q_empty", rd_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
